// File: rtl/aes_seq_pkg.sv
// ---------------------------------------------------------------------------
// aes_seq_pkg
// Shared definitions for the AES round sequencer and its helpers:
//   - state_e   : sequencer FSM states
//   - KL_*      : key_len encodings (3 is treated as 256-bit)
//   - NR_*_DEF  : default round counts per key size
// ---------------------------------------------------------------------------
package aes_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] KL_128 = 2'd0;
  localparam logic [1:0] KL_192 = 2'd1;
  localparam logic [1:0] KL_256 = 2'd2;

  localparam int NR_128_DEF = 10;
  localparam int NR_192_DEF = 12;
  localparam int NR_256_DEF = 14;

endpackage

// File: rtl/aes_nr_decode.sv
// ---------------------------------------------------------------------------
// aes_nr_decode
// Combinational key_len -> round count (Nr) lookup. Shared with the key
// expansion unit so both sides agree on Nr for a given key size.
// Ports:
//   key_len  in  2      key-size select (KL_128/KL_192/KL_256, 3 -> 256)
//   nr       out CNT_W  number of rounds for that key size
// ---------------------------------------------------------------------------
module aes_nr_decode
  import aes_seq_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int NR_128 = NR_128_DEF,
  parameter int NR_192 = NR_192_DEF,
  parameter int NR_256 = NR_256_DEF
) (
  input  logic [1:0]       key_len,
  output logic [CNT_W-1:0] nr
);

  always_comb begin
    nr = CNT_W'(NR_256);
    case (key_len)
      KL_128:  nr = CNT_W'(NR_128);
      KL_192:  nr = CNT_W'(NR_192);
      default: nr = CNT_W'(NR_256);
    endcase
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
// Round sequencer for the AES datapath. Supports 10/12/14 rounds selected per
// block by key_len at start, with start/busy/done handshake and an advance
// (stall) input.
//
// Optional build macro: AES_ROUND_DOWNCOUNT_EN
//   When defined, adds the decrypt input; a block started with decrypt=1
//   counts round_idx down from Nr to 0 instead of up from 0 to Nr.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   new block request (taken in IDLE or DONE only)
//   key_len      in   key-size select, latched on accepted start
//   advance      in   step enable; 0 stalls state and round_idx
//   decrypt      in   (macro only) count direction, latched on start
//   busy         out  high in INIT, ROUND, FINAL
//   round_idx    out  current round number
//   first_round  out  initial AddRoundKey-only round (INIT)
//   last_round   out  final round without MixColumns (FINAL)
//   mix_en       out  MixColumns enable (ROUND)
//   done         out  one-cycle completion pulse
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// INIT  | round 0 (or Nr when counting down), AddRoundKey only
// ROUND | middle rounds, MixColumns enabled
// FINAL | last round, round_idx at its terminal value
// DONE  | single-cycle done pulse; start here chains the next block
// ---------------------------------------------------------------------------
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int NR_128 = NR_128_DEF,
  parameter int NR_192 = NR_192_DEF,
  parameter int NR_256 = NR_256_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic             advance,
`ifdef AES_ROUND_DOWNCOUNT_EN
  input  logic             decrypt,
`endif
  output logic             busy,
  output logic [CNT_W-1:0] round_idx,
  output logic             first_round,
  output logic             last_round,
  output logic             mix_en,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] nr_q, nr_d;
  logic [CNT_W-1:0] nr_dec;
  logic [CNT_W-1:0] idx_step;
  logic [CNT_W-1:0] idx_end;
  logic             down_q, down_d;
  logic             down_in;

`ifdef AES_ROUND_DOWNCOUNT_EN
  assign down_in = decrypt;
`else
  assign down_in = 1'b0;
`endif

  aes_nr_decode #(
    .CNT_W  (CNT_W),
    .NR_128 (NR_128),
    .NR_192 (NR_192),
    .NR_256 (NR_256)
  ) u_nr_decode (
    .key_len (key_len),
    .nr      (nr_dec)
  );

  // Next index and the value that marks the FINAL round, by direction.
  assign idx_step = down_q ? (idx_q - CNT_W'(1)) : (idx_q + CNT_W'(1));
  assign idx_end  = down_q ? '0 : nr_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nr_d    = nr_q;
    down_d  = down_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
        if (start) begin
          state_d = S_INIT;
          nr_d    = nr_dec;
          down_d  = down_in;
          idx_d   = down_in ? nr_dec : '0;
        end
      end
      S_INIT, S_ROUND: begin
        if (advance) begin
          idx_d   = idx_step;
          state_d = (idx_step == idx_end) ? S_FINAL : S_ROUND;
        end
      end
      S_FINAL: begin
        if (advance) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      nr_q    <= CNT_W'(NR_128);
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nr_q    <= nr_d;
      down_q  <= down_d;
    end
  end

  // In up-count mode round_idx is 0 only in INIT while busy, so keying the
  // qualifiers on state covers both count directions.
  assign busy        = (state_q == S_INIT) || (state_q == S_ROUND) || (state_q == S_FINAL);
  assign first_round = (state_q == S_INIT);
  assign last_round  = (state_q == S_FINAL);
  assign mix_en      = (state_q == S_ROUND);
  assign done        = (state_q == S_DONE);
  assign round_idx   = idx_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
// Self-checking bench for aes_round_sequencer. A per-cycle reference built
// from advance counts pushes expected outputs to a scoreboard queue; a table
// of block records checks done latency and peak round index per key size.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [CNT_W-1:0] idx;
    logic             busy;
    logic             first;
    logic             last;
    logic             mix;
    logic             done;
  } obs_t;

  typedef struct {
    logic [1:0] kl;
    logic [1:0] kl_after;
    bit         dec;
    int         adv_mode;   // 1: advance always high, 2: toggles 1,0,1,0
    int         exp_peak;
    int         exp_lat;    // edges from accepting start to the done edge
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       key_len = 2'd0;
  logic             advance = 1'b0;
`ifdef AES_ROUND_DOWNCOUNT_EN
  logic             decrypt = 1'b0;
`endif
  logic             busy;
  logic [CNT_W-1:0] round_idx;
  logic             first_round;
  logic             last_round;
  logic             mix_en;
  logic             done;

  aes_round_sequencer #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .key_len     (key_len),
    .advance     (advance),
`ifdef AES_ROUND_DOWNCOUNT_EN
    .decrypt     (decrypt),
`endif
    .busy        (busy),
    .round_idx   (round_idx),
    .first_round (first_round),
    .last_round  (last_round),
    .mix_en      (mix_en),
    .done        (done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  obs_t sb_q[$];

  // Reference: block progress is the number of advances taken since INIT.
  bit m_act = 1'b0;
  int m_a   = 0;
  int m_nr  = 10;
  bit m_dec = 1'b0;

  function automatic int nr_of(logic [1:0] kl);
    case (kl)
      2'd0:    return 10;
      2'd1:    return 12;
      default: return 14;
    endcase
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    int   a_sat;
    o = '0;
    if (m_act) begin
      a_sat   = (m_a < m_nr) ? m_a : m_nr;
      o.busy  = (m_a <= m_nr);
      o.first = (m_a == 0);
      o.last  = (m_a == m_nr);
      o.mix   = (m_a >= 1) && (m_a < m_nr);
      o.done  = (m_a == m_nr + 1);
      o.idx   = m_dec ? CNT_W'(m_nr - a_sat) : CNT_W'(a_sat);
    end
    return o;
  endfunction

  task automatic model_step(bit rs, bit st, logic [1:0] kl, bit adv, bit dc);
    if (rs) begin
      m_act = 1'b0;
    end else if (!m_act || (m_a == m_nr + 1)) begin
      if (st) begin
        m_act = 1'b1;
        m_a   = 0;
        m_nr  = nr_of(kl);
        m_dec = dc;
      end else begin
        m_act = 1'b0;
      end
    end else if (adv) begin
      m_a++;
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(bit rs, bit st, logic [1:0] kl, bit adv, bit dc,
                      string tag, output obs_t got);
    obs_t e;
    reset   = rs;
    start   = st;
    key_len = kl;
    advance = adv;
`ifdef AES_ROUND_DOWNCOUNT_EN
    decrypt = dc;
`endif
    model_step(rs, st, kl, adv, dc);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    cyc++;
    got = {round_idx, busy, first_round, last_round, mix_en, done};
    e   = sb_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: got idx=%0d busy=%b first=%b last=%b mix=%b done=%b expected idx=%0d busy=%b first=%b last=%b mix=%b done=%b",
               tag, cyc, got.idx, got.busy, got.first, got.last, got.mix, got.done,
               e.idx, e.busy, e.first, e.last, e.mix, e.done);
    end
  endtask

  task automatic run_block(vec_t v);
    obs_t g;
    int   acc;
    int   done_at;
    int   peak;
    bit   adv;
    done_at = -1;
    step(1'b0, 1'b1, v.kl, 1'b0, v.dec, "accept", g);
    acc  = cyc;
    peak = int'(g.idx);
    for (int i = 0; i < 60 && done_at < 0; i++) begin
      adv = (v.adv_mode == 1) ? 1'b1 : ((i % 2) == 0);
      step(1'b0, 1'b0, v.kl_after, adv, v.dec, "block", g);
      if (int'(g.idx) > peak) peak = int'(g.idx);
      if (g.done) done_at = cyc;
    end
    check_int("done_latency", (done_at < 0) ? -1 : done_at - acc, v.exp_lat);
    check_int("peak_idx", peak, v.exp_peak);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "back_to_idle", g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    obs_t g;
    int   done_cycles[$];
    int   n_done;
    bit   hit5;

    vecs.push_back('{kl: 2'd0, kl_after: 2'd0, dec: 1'b0, adv_mode: 1, exp_peak: 10, exp_lat: 11});
    vecs.push_back('{kl: 2'd2, kl_after: 2'd2, dec: 1'b0, adv_mode: 2, exp_peak: 14, exp_lat: 29});
    vecs.push_back('{kl: 2'd3, kl_after: 2'd3, dec: 1'b0, adv_mode: 1, exp_peak: 14, exp_lat: 15});
    vecs.push_back('{kl: 2'd3, kl_after: 2'd0, dec: 1'b0, adv_mode: 1, exp_peak: 14, exp_lat: 15});
    vecs.push_back('{kl: 2'd1, kl_after: 2'd1, dec: 1'b0, adv_mode: 1, exp_peak: 12, exp_lat: 13});
    vecs.push_back('{kl: 2'd0, kl_after: 2'd2, dec: 1'b0, adv_mode: 2, exp_peak: 10, exp_lat: 21});
`ifdef AES_ROUND_DOWNCOUNT_EN
    vecs.push_back('{kl: 2'd0, kl_after: 2'd0, dec: 1'b1, adv_mode: 1, exp_peak: 10, exp_lat: 11});
    vecs.push_back('{kl: 2'd2, kl_after: 2'd1, dec: 1'b1, adv_mode: 2, exp_peak: 14, exp_lat: 29});
`endif

    // Reset state, then advance alone must not leave IDLE.
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "reset", g);
    step(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, "reset_prio", g);
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, "idle_adv", g);
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, "idle_adv", g);

    foreach (vecs[i]) run_block(vecs[i]);

    // Start held high: back-to-back 12-round blocks, one done every 14 edges.
    for (int i = 0; i < 45; i++) begin
      step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, "b2b", g);
      if (g.done) done_cycles.push_back(cyc);
    end
    check_int("b2b_done_count", done_cycles.size(), 3);
    for (int i = 1; i < done_cycles.size(); i++)
      check_int("b2b_done_period", done_cycles[i] - done_cycles[i-1], 14);
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, "b2b_drain", g);

    // Reset mid-block at round 5: back to IDLE, no done for the aborted block.
    step(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, "abort_accept", g);
    hit5 = 1'b0;
    for (int i = 0; i < 20 && !hit5; i++) begin
      step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, "abort_run", g);
      if (g.idx == CNT_W'(5)) hit5 = 1'b1;
    end
    check_int("abort_reached_5", int'(hit5), 1);
    step(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, "abort_reset", g);
    check_int("abort_idx", int'(g.idx), 0);
    check_int("abort_busy", int'(g.busy), 0);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, "abort_after", g);
      if (g.done) n_done++;
    end
    check_int("abort_no_done", n_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
